// File: rtl/hmac_pkg.sv
// Shared definitions for the HMAC-Ascon receive path: FSM states, error codes
// and the default word/tag geometry used by both the verifier and the controller.
package hmac_pkg;

    localparam int HMAC_WORD_W    = 64;
    localparam int HMAC_TAG_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        TAG_RX,
        START,
        MSG_FWD,
        DRAIN,
        WAIT_TAG,
        COMPARE,
        REPORT
    } state_e;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        TIMEOUT    = 2'd1,
        OVERLENGTH = 2'd2
    } err_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hmac_tag_cmp.sv
// Word-serial tag comparator: one word per cycle, always TAG_WORDS cycles,
// so the time taken never reveals where (or whether) the tags differ.
module hmac_tag_cmp
    import hmac_pkg::*;
#(
    parameter int WORD_W    = HMAC_WORD_W,
    parameter int TAG_WORDS = HMAC_TAG_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [WORD_W-1:0] tag_a [TAG_WORDS],
    input  logic [WORD_W-1:0] tag_b [TAG_WORDS],
    output logic              done,
    output logic              match
);

    localparam int               IDX_W    = width_of(TAG_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAG_WORDS - 1);

    logic              busy;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            idx  <= '0;
            diff <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            idx  <= '0;
            diff <= '0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
            diff <= '0;
        end else if (busy) begin
            // Accumulate every differing bit; no early exit on the first mismatch.
            diff <= diff | (tag_a[idx] ^ tag_b[idx]);
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign done  = busy && (idx == LAST_IDX);
    assign match = (diff == '0);

endmodule

// File: rtl/hmac_tag_verifier.sv
// Receive-side HMAC tag checker: captures the expected tag, drives the engine
// with the message and reports a constant-time match result with an error code.
module hmac_tag_verifier
    import hmac_pkg::*;
#(
    parameter int WORD_W         = HMAC_WORD_W,
    parameter int TAG_WORDS      = HMAC_TAG_WORDS,
    parameter int MAX_MSG_WORDS  = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tag_valid,
    output logic                        tag_ready,
    input  logic [WORD_W-1:0]           tag_data,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    input  logic [WORD_W-1:0]           msg_data,
    input  logic                        msg_last,
    output logic                        eng_start,
    output logic                        eng_msg_valid,
    input  logic                        eng_msg_ready,
    output logic [WORD_W-1:0]           eng_msg_data,
    output logic                        eng_msg_last,
    input  logic                        eng_tag_valid,
    input  logic [TAG_WORDS*WORD_W-1:0] eng_tag,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        result_ok,
    output logic [1:0]                  result_err
);

    localparam int                CNT_W    = width_of(MAX_MSG_WORDS);
    localparam int                TMR_W    = width_of(TIMEOUT_CYCLES);
    localparam int                TIDX_W   = width_of(TAG_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_MSG_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIDX_W-1:0] TAG_LAST = TIDX_W'(TAG_WORDS - 1);

    state_e             state, state_next;
    err_e               err;
    logic [WORD_W-1:0]  tag_q [TAG_WORDS];
    logic [WORD_W-1:0]  eng_q [TAG_WORDS];
    logic [TIDX_W-1:0]  tag_idx;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   timer;

    logic forced_last;
    logic fwd_fire;
    logic cmp_start;
    logic cmp_clear;
    logic cmp_done;
    logic cmp_match;

    assign forced_last = (cnt == CNT_LAST);
    assign fwd_fire    = (state == MSG_FWD) && msg_valid && eng_msg_ready;
    assign cmp_start   = (state == WAIT_TAG) && eng_tag_valid;
    assign cmp_clear   = (state == REPORT) && result_ready;

    always_comb begin
        state_next    = state;
        tag_ready     = 1'b0;
        msg_ready     = 1'b0;
        eng_start     = 1'b0;
        eng_msg_valid = 1'b0;
        eng_msg_data  = '0;
        eng_msg_last  = 1'b0;
        result_valid  = 1'b0;
        result_ok     = 1'b0;
        result_err    = NONE;

        case (state)
            IDLE: begin
                if (tag_valid) state_next = TAG_RX;
            end
            TAG_RX: begin
                tag_ready = 1'b1;
                if (tag_valid && (tag_idx == TAG_LAST)) state_next = START;
            end
            START: begin
                eng_start  = 1'b1;
                state_next = MSG_FWD;
            end
            MSG_FWD: begin
                // Pure pass-through so forwarding costs no cycles and backpressure is immediate.
                eng_msg_valid = msg_valid;
                msg_ready     = eng_msg_ready;
                eng_msg_data  = msg_data;
                eng_msg_last  = msg_last | forced_last;
                if (fwd_fire) begin
                    if (msg_last)         state_next = WAIT_TAG;
                    else if (forced_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                msg_ready = 1'b1;
                if (msg_valid && msg_last) state_next = WAIT_TAG;
            end
            WAIT_TAG: begin
                if (eng_tag_valid)          state_next = COMPARE;
                else if (timer == TMR_LAST) state_next = REPORT;
            end
            COMPARE: begin
                if (cmp_done) state_next = REPORT;
            end
            REPORT: begin
                result_valid = 1'b1;
                result_ok    = cmp_match && (err == NONE);
                result_err   = err;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            err     <= NONE;
            tag_idx <= '0;
            cnt     <= '0;
            timer   <= '0;
            for (int i = 0; i < TAG_WORDS; i++) begin
                tag_q[i] <= '0;
                eng_q[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                TAG_RX: begin
                    if (tag_valid) begin
                        tag_q[tag_idx] <= tag_data;
                        tag_idx        <= (tag_idx == TAG_LAST) ? '0 : tag_idx + 1'b1;
                    end
                end
                MSG_FWD: begin
                    if (fwd_fire) begin
                        cnt <= cnt + 1'b1;
                        if (!msg_last && forced_last) err <= OVERLENGTH;
                    end
                end
                WAIT_TAG: begin
                    if (eng_tag_valid) begin
                        for (int i = 0; i < TAG_WORDS; i++) begin
                            eng_q[i] <= eng_tag[i*WORD_W +: WORD_W];
                        end
                    end else if (timer == TMR_LAST) begin
                        err <= TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPORT: begin
                    // Zeroise all secret-bearing and per-message state on exit.
                    if (result_ready) begin
                        err     <= NONE;
                        tag_idx <= '0;
                        cnt     <= '0;
                        timer   <= '0;
                        for (int i = 0; i < TAG_WORDS; i++) begin
                            tag_q[i] <= '0;
                            eng_q[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    hmac_tag_cmp #(
        .WORD_W    (WORD_W),
        .TAG_WORDS (TAG_WORDS)
    ) u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cmp_start),
        .clear (cmp_clear),
        .tag_a (tag_q),
        .tag_b (eng_q),
        .done  (cmp_done),
        .match (cmp_match)
    );

endmodule

// File: tb/tb_hmac_tag_verifier.sv
// Self-checking bench for hmac_tag_verifier: directed and randomized transactions
// checked against a message-level reference model of the expected outcome.
module tb_hmac_tag_verifier;

    localparam int WORD_W    = 64;
    localparam int TAG_WORDS = 4;
    localparam int MAX_MSG   = 4;
    localparam int TIMEOUT   = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        tag_valid;
    logic                        tag_ready;
    logic [WORD_W-1:0]           tag_data;
    logic                        msg_valid;
    logic                        msg_ready;
    logic [WORD_W-1:0]           msg_data;
    logic                        msg_last;
    logic                        eng_start;
    logic                        eng_msg_valid;
    logic                        eng_msg_ready;
    logic [WORD_W-1:0]           eng_msg_data;
    logic                        eng_msg_last;
    logic                        eng_tag_valid;
    logic [TAG_WORDS*WORD_W-1:0] eng_tag;
    logic                        result_valid;
    logic                        result_ready;
    logic                        result_ok;
    logic [1:0]                  result_err;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [WORD_W-1:0] tag_w [TAG_WORDS];
    logic [WORD_W-1:0] eng_w [TAG_WORDS];
    logic [WORD_W-1:0] msg [$];
    logic [WORD_W-1:0] fwd_data [$];
    logic              fwd_last [$];
    int                start_count = 0;
    int                start_cyc   = -1;

    hmac_tag_verifier #(
        .WORD_W         (WORD_W),
        .TAG_WORDS      (TAG_WORDS),
        .MAX_MSG_WORDS  (MAX_MSG),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tag_valid     (tag_valid),
        .tag_ready     (tag_ready),
        .tag_data      (tag_data),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_data      (msg_data),
        .msg_last      (msg_last),
        .eng_start     (eng_start),
        .eng_msg_valid (eng_msg_valid),
        .eng_msg_ready (eng_msg_ready),
        .eng_msg_data  (eng_msg_data),
        .eng_msg_last  (eng_msg_last),
        .eng_tag_valid (eng_tag_valid),
        .eng_tag       (eng_tag),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_ok     (result_ok),
        .result_err    (result_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine-side observer, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (eng_start) begin
            start_count++;
            start_cyc = cyc;
        end
        if (eng_msg_valid && eng_msg_ready) begin
            fwd_data.push_back(eng_msg_data);
            fwd_last.push_back(eng_msg_last);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Runs one full transaction starting at posedge+1 and returns at posedge+1.
    task automatic applyStimulus(input int len, input bit respond, input bit random_bp, input int stall);
        int         widx, guard, t_cyc, l_cyc, n_cyc, rv_cyc, exp_fwd, bp_bad;
        bit         exp_ok, stable;
        logic [1:0] exp_err;
        logic       obs_ok;
        logic [1:0] obs_err;

        exp_fwd = (len > MAX_MSG) ? MAX_MSG : len;
        exp_ok  = respond && (len <= MAX_MSG);
        for (int i = 0; i < TAG_WORDS; i++) if (tag_w[i] != eng_w[i]) exp_ok = 1'b0;
        exp_err = !respond ? 2'd1 : (len > MAX_MSG) ? 2'd2 : 2'd0;

        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back({$urandom, $urandom});
        fwd_data.delete();
        fwd_last.delete();
        start_count = 0;
        start_cyc   = -1;

        widx = 0; guard = 0; t_cyc = -1;
        while (widx < TAG_WORDS && guard < 20) begin
            tag_valid = 1'b1;
            tag_data  = tag_w[widx];
            #1;
            if (tag_ready) begin
                widx++;
                if (widx == TAG_WORDS) t_cyc = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        tag_valid = 1'b0;
        tag_data  = '0;
        checkOutput("tag_words_accepted", widx, TAG_WORDS);

        widx = 0; guard = 0; l_cyc = -1; bp_bad = 0;
        while (widx < len && guard < 200) begin
            msg_valid     = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            msg_data      = msg[widx];
            msg_last      = (widx == len - 1);
            eng_msg_ready = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (start_count > 0 && widx < exp_fwd && msg_ready !== eng_msg_ready) bp_bad++;
            if (msg_valid && msg_ready) begin
                widx++;
                if (widx == len) l_cyc = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        msg_valid     = 1'b0;
        msg_last      = 1'b0;
        msg_data      = '0;
        eng_msg_ready = 1'b0;
        checkOutput("msg_words_accepted", widx, len);
        checkOutput("backpressure_follow", bp_bad, 0);
        checkOutput("start_pulse_count", start_count, 1);
        checkOutput("start_pulse_cycle", start_cyc, t_cyc + 1);

        n_cyc = -1;
        if (respond) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            eng_tag_valid = 1'b1;
            for (int i = 0; i < TAG_WORDS; i++) eng_tag[i*WORD_W +: WORD_W] = eng_w[i];
            n_cyc = cyc;
            @(posedge clk); #1;
            eng_tag_valid = 1'b0;
            eng_tag       = '0;
        end

        guard = 0; rv_cyc = -1;
        while (rv_cyc < 0 && guard < 100) begin
            #1;
            if (result_valid) rv_cyc = cyc;
            else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        checkOutput("result_latency", rv_cyc, respond ? n_cyc + TAG_WORDS + 1 : l_cyc + 1 + TIMEOUT);

        obs_ok  = result_ok;
        obs_err = result_err;
        checkOutput("result_ok", obs_ok, exp_ok);
        checkOutput("result_err", obs_err, exp_err);

        if (stall > 0) begin
            stable = 1'b1;
            repeat (stall) begin
                @(posedge clk); #2;
                if (result_valid !== 1'b1 || result_ok !== obs_ok || result_err !== obs_err) stable = 1'b0;
            end
            checkOutput("result_stable_in_stall", stable, 1'b1);
        end

        @(posedge clk); #1;
        result_ready = 1'b1;
        tag_valid    = 1'b1;
        tag_data     = {$urandom, $urandom};
        #1;
        checkOutput("tag_blocked_in_report", tag_ready, 1'b0);
        @(posedge clk); #1;
        result_ready = 1'b0;
        tag_valid    = 1'b0;
        tag_data     = '0;
        #1;
        checkOutput("result_cleared", result_valid, 1'b0);

        checkOutput("fwd_count", fwd_data.size(), exp_fwd);
        for (int i = 0; i < fwd_data.size() && i < exp_fwd; i++) begin
            checkOutput("fwd_data", fwd_data[i], msg[i]);
            checkOutput("fwd_last", fwd_last[i], (i == exp_fwd - 1));
        end

        @(posedge clk); #1;
    endtask

    initial begin
        int rv_seen;
        rst_n         = 1'b0;
        tag_valid     = 1'b0;
        tag_data      = '0;
        msg_valid     = 1'b0;
        msg_data      = '0;
        msg_last      = 1'b0;
        eng_msg_ready = 1'b0;
        eng_tag_valid = 1'b0;
        eng_tag       = '0;
        result_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl_outputs",
                    {tag_ready, msg_ready, eng_start, eng_msg_valid, eng_msg_last, result_valid, result_ok, result_err},
                    '0);
        checkOutput("reset_msg_data", eng_msg_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] match, 3-word message");
        for (int i = 0; i < TAG_WORDS; i++) begin
            tag_w[i] = 64'h0123_4567_89AB_CDEF;
            eng_w[i] = 64'h0123_4567_89AB_CDEF;
        end
        applyStimulus(3, 1'b1, 1'b0, 0);

        $display("[TB] mismatch in word 3 bit 0");
        eng_w[3] = eng_w[3] ^ 64'd1;
        applyStimulus(3, 1'b1, 1'b0, 0);

        $display("[TB] overlength, 6-word message");
        eng_w[3] = tag_w[3];
        applyStimulus(6, 1'b1, 1'b0, 0);

        $display("[TB] engine timeout");
        applyStimulus(2, 1'b0, 1'b0, 0);

        $display("[TB] randomized backpressure and result stall");
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < TAG_WORDS; i++) begin
                tag_w[i] = {$urandom, $urandom};
                eng_w[i] = tag_w[i];
            end
            if (t % 2 == 1) eng_w[$urandom_range(0, TAG_WORDS - 1)][$urandom_range(0, WORD_W - 1)] ^= 1'b1;
            applyStimulus($urandom_range(1, MAX_MSG), 1'b1, 1'b1, (t == 0) ? 10 : $urandom_range(1, 3));
        end

        $display("[TB] reset during message forwarding");
        start_count = 0;
        tag_valid   = 1'b1;
        repeat (TAG_WORDS + 1) begin
            tag_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        tag_valid     = 1'b0;
        msg_valid     = 1'b1;
        msg_data      = {$urandom, $urandom};
        msg_last      = 1'b0;
        eng_msg_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_reached_fwd", eng_msg_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs_cleared",
                    {tag_ready, msg_ready, eng_start, eng_msg_valid, eng_msg_last, result_valid, result_ok, result_err},
                    '0);
        @(posedge clk); #1;
        msg_valid     = 1'b0;
        eng_msg_ready = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        start_count = 0;
        rv_seen     = 0;
        eng_tag_valid = 1'b1;
        eng_tag       = '1;
        @(posedge clk); #1;
        eng_tag_valid = 1'b0;
        eng_tag       = '0;
        repeat (30) begin
            @(posedge clk); #1;
            if (result_valid) rv_seen++;
        end
        checkOutput("no_result_after_abort", rv_seen, 0);
        checkOutput("no_start_after_abort", start_count, 0);

        for (int i = 0; i < TAG_WORDS; i++) begin
            tag_w[i] = {$urandom, $urandom};
            eng_w[i] = tag_w[i];
        end
        applyStimulus(3, 1'b1, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hmac_tag_verifier.md
# hmac_tag_verifier

Receive-side checker for HMAC-Ascon authenticated messages. It captures the expected tag from the link, starts the HMAC engine, and streams the message words to it. It then compares the engine's computed tag against the expected tag in constant time and reports pass/fail with an error code. It sits between the link receiver and the HMAC-Ascon controller/engine, acting as the consumer of the engine's result.

## Interface
Parameters:
- WORD_W, 64: message/tag word width in bits
- TAG_WORDS, 4: tag length in words (256-bit Ascon-Hash tag)
- MAX_MSG_WORDS, 1024: maximum accepted message length in words; must be ≥1
- TIMEOUT_CYCLES, 4096: maximum cycles spent waiting for the engine tag

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- tag_valid / tag_ready  in / out  1 / 1  expected-tag word handshake
- tag_data  in  WORD_W  expected-tag word, word 0 first
- msg_valid / msg_ready  in / out  1 / 1  message word handshake
- msg_data  in  WORD_W  message word
- msg_last  in  1  marks the final message word
- eng_start  out  1  one-cycle pulse that starts an HMAC computation
- eng_msg_valid / eng_msg_ready  out / in  1 / 1  message forward handshake
- eng_msg_data  out  WORD_W  forwarded word
- eng_msg_last  out  1  final forwarded word
- eng_tag_valid  in  1  computed tag present (single-cycle pulse)
- eng_tag  in  TAG_WORDS*WORD_W  computed tag, word 0 in the LSBs
- result_valid / result_ready  out / in  1 / 1  result handshake
- result_ok  out  1  1 = tags match and no error
- result_err  out  2  0 NONE, 1 TIMEOUT, 2 OVERLENGTH

## Operation
- States and transitions:
  - IDLE → TAG_RX when tag_valid is high.
  - TAG_RX: tag_ready=1. Store TAG_WORDS words into tag_q[idx]. After the last word → START.
  - START: eng_start=1 for exactly one cycle → MSG_FWD.
  - MSG_FWD: combinational pass-through.
    - eng_msg_valid=msg_valid, msg_ready=eng_msg_ready, eng_msg_data=msg_data.
    - eng_msg_last = msg_last | (cnt==MAX_MSG_WORDS-1).
    - cnt increments on each transfer.
    - A transfer with msg_last → WAIT_TAG.
    - A forced last transfer without msg_last → set err=OVERLENGTH → DRAIN.
  - DRAIN: msg_ready=1, eng_msg_valid=0. Discard words until the msg_last transfer → WAIT_TAG.
  - WAIT_TAG: timer counts up.
    - eng_tag_valid → latch eng_tag into eng_q → COMPARE.
    - If the timer reaches TIMEOUT_CYCLES-1 without a tag → err=TIMEOUT → REPORT.
  - COMPARE: TAG_WORDS cycles, word-serial: diff |= tag_q[i]^eng_q[i]. Duration does not depend on the data (no early exit) → REPORT.
  - REPORT: result_valid=1, result_ok=(diff==0)&&(err==NONE). Hold until result_ready → IDLE.
- Leaving REPORT zeroises tag_q, eng_q, diff, err, cnt and timer.
- OVERLENGTH still waits for the engine tag and still runs COMPARE, but forces result_ok=0.
- eng_tag_valid outside WAIT_TAG is ignored. tag_valid outside IDLE/TAG_RX is not acknowledged (tag_ready=0).
- Zero-length messages are not supported; the minimum message is one word with msg_last set.

## Timing
- Reset values: all outputs 0 (tag_ready, msg_ready, eng_start, eng_msg_valid, eng_msg_last, eng_msg_data, result_valid, result_ok, result_err). Internal registers are zeroed and the state is IDLE.
- Reset mid-operation: abort immediately. No eng_start, no result, all tag storage is cleared.
- Tag capture: at one word per cycle, the TAG_WORDS-th word is accepted in cycle T and eng_start is high in cycle T+1.
- Forwarding adds zero cycles of latency. Backpressure from eng_msg_ready reaches msg_ready in the same cycle.
- eng_tag_valid sampled at cycle N → result_valid first high at N+TAG_WORDS+1.
- Timeout: result_valid rises TIMEOUT_CYCLES cycles after WAIT_TAG is entered.
- result_* outputs are stable while result_valid=1 and result_ready=0.
- Same-cycle result_ready and new tag_valid: the verifier returns to IDLE first. The new tag is accepted no earlier than the next cycle.

## Structure
- Shared package hmac_pkg holds:
  - the state enum (IDLE, TAG_RX, START, MSG_FWD, DRAIN, WAIT_TAG, COMPARE, REPORT)
  - the err_e codes (NONE=0, TIMEOUT=1, OVERLENGTH=2)
  - the default WORD_W and TAG_WORDS constants, shared with the HMAC controller.
- Sub-module hmac_tag_cmp: word-serial constant-time comparator with start/done, index counter and diff accumulator. The top-level holds the FSM, counters and handshakes.

## Test plan
- Match: tag = eng_tag = 0x0123…EF (4 words), 3-word message with eng_msg_ready=1 → one eng_start pulse, 3 forwarded words with last on word 3, result_ok=1, err=0, result_valid at N+5.
- Mismatch in word 3 bit 0 only → result_ok=0, err=0; COMPARE lasts exactly 4 cycles, the same as for a match.
- Overlength: MAX_MSG_WORDS=4, 6-word message → word 4 forwarded with eng_msg_last=1, words 5–6 dropped with msg_ready=1, result_ok=0, err=2.
- Timeout: TIMEOUT_CYCLES=16, engine never returns a tag → result_valid 16 cycles after WAIT_TAG is entered, err=1, ok=0.
- Backpressure and result stall: eng_msg_ready toggled randomly → no word lost or duplicated. result_ready held low for 10 cycles → outputs stable, then IDLE.
- Reset asserted during MSG_FWD, then a new transaction → no result from the aborted transaction; the new one passes with correct values.
